// File: rtl/fxp_op_sequencer.sv
// -----------------------------------------------------------------------------
// fxp_op_sequencer
//
// Front-end sequencer for the fixed-point arithmetic units. It takes one
// operation request (opcode, A, B) over a valid/ready handshake and registers
// the operands onto the shared unit operand buses.
//   - Add: the adder is combinational, so its result is captured one cycle
//     after the accept.
//   - Multiply/divide: the sequencer waits for the target unit to be idle,
//     pulses its start for one cycle, waits for the unit to go busy and then
//     waits for it to report complete again. The whole exchange is guarded by
//     a cycle timeout.
//   - A divide whose divisor magnitude is zero is answered directly with a
//     saturated result and never reaches the divider.
// The result and a status word are returned over a second valid/ready
// handshake.
//
// Ports
//   FXP_SEQ_CLOCK_50            system clock
//   FXP_SEQ_Reset_InLow         asynchronous reset, active low
//   FXP_SEQ_ReqValid_InHigh     request valid
//   FXP_SEQ_ReqReady_Out        request ready (high only in IDLE)
//   FXP_SEQ_Opcode_BusIn        00 add, 01 mult, 10 div, 11 illegal
//   FXP_SEQ_Aop_BusIn/Bop_BusIn request operands (sign-magnitude)
//   FXP_SEQ_UnitA/UnitB_BusOut  registered operands to adder/mult/div
//   FXP_SEQ_Mult/Div_Start_Out  one-cycle start pulses
//   FXP_SEQ_Mult/Div_Comp_In    unit complete (high = idle/done)
//   FXP_SEQ_Mult/Div_Over_In    unit overflow flag
//   FXP_SEQ_*_Result_BusIn      unit results
//   FXP_SEQ_Result_BusOut       response result
//   FXP_SEQ_Status_BusOut       [0] overflow [1] div-by-zero [2] timeout
//                               [3] illegal opcode
//   FXP_SEQ_RspValid_Out        response valid
//   FXP_SEQ_RspReady_InHigh     response consumer ready
// -----------------------------------------------------------------------------
module fxp_op_sequencer #(
  parameter int DATAWIDTH_N    = 32,
  parameter int FRACTIONAL_Q   = 15,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                   FXP_SEQ_CLOCK_50,
  input  logic                   FXP_SEQ_Reset_InLow,
  input  logic                   FXP_SEQ_ReqValid_InHigh,
  output logic                   FXP_SEQ_ReqReady_Out,
  input  logic [1:0]             FXP_SEQ_Opcode_BusIn,
  input  logic [DATAWIDTH_N-1:0] FXP_SEQ_Aop_BusIn,
  input  logic [DATAWIDTH_N-1:0] FXP_SEQ_Bop_BusIn,
  output logic [DATAWIDTH_N-1:0] FXP_SEQ_UnitA_BusOut,
  output logic [DATAWIDTH_N-1:0] FXP_SEQ_UnitB_BusOut,
  output logic                   FXP_SEQ_Mult_Start_Out,
  output logic                   FXP_SEQ_Div_Start_Out,
  input  logic                   FXP_SEQ_Mult_Comp_In,
  input  logic                   FXP_SEQ_Div_Comp_In,
  input  logic                   FXP_SEQ_Mult_Over_In,
  input  logic                   FXP_SEQ_Div_Over_In,
  input  logic [DATAWIDTH_N-1:0] FXP_SEQ_Add_Result_BusIn,
  input  logic [DATAWIDTH_N-1:0] FXP_SEQ_Mult_Result_BusIn,
  input  logic [DATAWIDTH_N-1:0] FXP_SEQ_Div_Result_BusIn,
  output logic [DATAWIDTH_N-1:0] FXP_SEQ_Result_BusOut,
  output logic [3:0]             FXP_SEQ_Status_BusOut,
  output logic                   FXP_SEQ_RspValid_Out,
  input  logic                   FXP_SEQ_RspReady_InHigh
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  localparam logic [3:0] ST_DIV_ZERO = 4'b0010;
  localparam logic [3:0] ST_TIMEOUT  = 4'b0100;
  localparam logic [3:0] ST_ILLEGAL  = 4'b1000;

  // The sequencer never interprets the fraction, but a Q that does not fit in
  // the magnitude field means the surrounding units are misconfigured.
  if (FRACTIONAL_Q < 0 || FRACTIONAL_Q > DATAWIDTH_N - 1) begin : g_bad_fractional_q
    $error("fxp_op_sequencer: FRACTIONAL_Q does not fit the magnitude field");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADD_CAP,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             op;
  logic [CNT_W-1:0]       cnt;
  logic [DATAWIDTH_N-1:0] unit_a;
  logic [DATAWIDTH_N-1:0] unit_b;
  logic [DATAWIDTH_N-1:0] result;
  logic [3:0]             status;

  logic                   accept;
  logic                   div_zero;
  logic                   is_div;
  logic                   tgt_comp;
  logic                   tgt_over;
  logic [DATAWIDTH_N-1:0] tgt_result;
  logic                   in_unit_wait;
  logic                   timed_out;

  // Only IDLE offers ReqReady, so a valid request in IDLE is an accept.
  assign accept   = (state == IDLE) && FXP_SEQ_ReqValid_InHigh;
  // Sign-magnitude: +0 and -0 both count as a zero divisor.
  assign div_zero = (FXP_SEQ_Bop_BusIn[DATAWIDTH_N-2:0] == '0);

  // Only multiply and divide reach the unit states, so the latched opcode
  // alone selects which unit's handshake is observed.
  assign is_div     = (op == OP_DIV);
  assign tgt_comp   = is_div ? FXP_SEQ_Div_Comp_In       : FXP_SEQ_Mult_Comp_In;
  assign tgt_over   = is_div ? FXP_SEQ_Div_Over_In       : FXP_SEQ_Mult_Over_In;
  assign tgt_result = is_div ? FXP_SEQ_Div_Result_BusIn  : FXP_SEQ_Mult_Result_BusIn;

  assign in_unit_wait = (state == ISSUE) || (state == WAIT_ACK) || (state == WAIT_DONE);
  assign timed_out    = in_unit_wait && (cnt == CNT_W'(TIMEOUT_CYCLES));

  assign FXP_SEQ_UnitA_BusOut  = unit_a;
  assign FXP_SEQ_UnitB_BusOut  = unit_b;
  assign FXP_SEQ_Result_BusOut = result;
  assign FXP_SEQ_Status_BusOut = status;

  // State register.
  always_ff @(posedge FXP_SEQ_CLOCK_50 or negedge FXP_SEQ_Reset_InLow) begin
    if (!FXP_SEQ_Reset_InLow) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A timeout wins over any unit handshake seen in the same
  // cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (FXP_SEQ_ReqValid_InHigh) begin
          case (FXP_SEQ_Opcode_BusIn)
            OP_ADD:  state_next = ADD_CAP;
            OP_MULT: state_next = ISSUE;
            OP_DIV:  state_next = div_zero ? RESP : ISSUE;
            default: state_next = RESP;
          endcase
        end
      end
      ADD_CAP: state_next = RESP;
      ISSUE: begin
        if (timed_out)     state_next = RESP;
        else if (tgt_comp) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (timed_out)      state_next = RESP;
        else if (!tgt_comp) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timed_out)     state_next = RESP;
        else if (tgt_comp) state_next = RESP;
      end
      RESP: begin
        if (FXP_SEQ_RspReady_InHigh) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs. The start pulse is issued only in the ISSUE cycle where
  // the unit reports idle; ISSUE is left on that same edge, so it lasts
  // exactly one cycle.
  always_comb begin
    FXP_SEQ_ReqReady_Out   = 1'b0;
    FXP_SEQ_RspValid_Out   = 1'b0;
    FXP_SEQ_Mult_Start_Out = 1'b0;
    FXP_SEQ_Div_Start_Out  = 1'b0;
    case (state)
      IDLE: FXP_SEQ_ReqReady_Out = 1'b1;
      ISSUE: begin
        if (!timed_out && tgt_comp) begin
          if (is_div) FXP_SEQ_Div_Start_Out  = 1'b1;
          else        FXP_SEQ_Mult_Start_Out = 1'b1;
        end
      end
      RESP: FXP_SEQ_RspValid_Out = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, timeout counter, result and status. Responses
  // decided at accept time (illegal opcode, zero divisor) are written here
  // directly so RESP can present them on the following cycle. Result and
  // status are otherwise untouched, which keeps them stable while RESP waits
  // for the consumer.
  always_ff @(posedge FXP_SEQ_CLOCK_50 or negedge FXP_SEQ_Reset_InLow) begin
    if (!FXP_SEQ_Reset_InLow) begin
      unit_a <= '0;
      unit_b <= '0;
      op     <= OP_ADD;
      cnt    <= '0;
      result <= '0;
      status <= '0;
    end else begin
      if (accept) begin
        unit_a <= FXP_SEQ_Aop_BusIn;
        unit_b <= FXP_SEQ_Bop_BusIn;
        op     <= FXP_SEQ_Opcode_BusIn;
        cnt    <= '0;
        if (FXP_SEQ_Opcode_BusIn == 2'b11) begin
          result <= '0;
          status <= ST_ILLEGAL;
        end else if (FXP_SEQ_Opcode_BusIn == OP_DIV && div_zero) begin
          result <= {FXP_SEQ_Aop_BusIn[DATAWIDTH_N-1], {(DATAWIDTH_N-1){1'b1}}};
          status <= ST_DIV_ZERO;
        end
      end else if (in_unit_wait) begin
        cnt <= cnt + CNT_W'(1);
        if (timed_out) begin
          result <= '0;
          status <= ST_TIMEOUT;
        end else if (state == WAIT_DONE && tgt_comp) begin
          result <= tgt_result;
          status <= {3'b000, tgt_over};
        end
      end else if (state == ADD_CAP) begin
        result <= FXP_SEQ_Add_Result_BusIn;
        status <= '0;
      end
    end
  end

endmodule
